keypad_scanner: RTL and testbench

//  Scans a 4x4 membrane keypad by driving rows and sampling columns. It resolves
//  one debounced key press into a 4-bit hex code plus a one-cycle valid strobe.
//  It is the producer for the seven-segment decoder: key_code feeds the decoder's
//  4-bit input directly. Key legends map to hex: '*'=E, '#'=F.

---
 rtl/keypad_scanner_if.sv | 33 +++
 rtl/keypad_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad matrix wires and the decoded key outputs of the scanner.
//   col_n     : column inputs from the keypad, active-low
//   row_n     : row drives to the keypad, active-low, one row low at a time
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle strobe when a new debounced press is accepted
//   key_down  : level, a debounced key is currently held
// The scanner uses the master modport; the keypad/consumer side uses slave.
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 membrane keypad one row at a time, classifies each full frame
// as no key / one key / several keys, and debounces a single key into a hex
// code with a one-cycle valid strobe. Key legends '*' and '#' map to E and F.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous, active-low reset
//   kp      : keypad_scanner_if.master (col_n in, row_n/key_code/key_valid/
//             key_down out)
// Parameters:
//   SCAN_DIV       : clock cycles each row is driven (min 4)
//   DEBOUNCE_SCANS : identical frames needed to accept a press/release (min 2)
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  keypad_scanner_if.master  kp
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  logic [3:0]        r_colMeta;
  logic [3:0]        r_colSync;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_row;
  logic [1:0]        r_lowCount;
  logic [3:0]        r_keyAcc;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_cand;
  logic [3:0]        r_keyCode;
  logic              r_keyValid;
  logic              r_keyDown;

  logic [3:0] w_colLow;
  logic [2:0] w_rowCount;
  logic [1:0] w_rowCol;
  logic [2:0] w_sum;
  logic [1:0] w_totalLow;
  logic [3:0] w_frameKey;
  logic       w_slotEnd;
  logic       w_frameTick;
  logic       w_isNone;
  logic       w_isSingle;

  // Physical legend of the key at a given row/column position.
  function automatic logic [3:0] mapKey(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer: col_n is asynchronous to clk and is only ever
  // observed through r_colSync. Idle (all high) is the reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_colMeta <= 4'hF;
      r_colSync <= 4'hF;
    end else begin
      r_colMeta <= kp.col_n;
      r_colSync <= r_colMeta;
    end
  end

  // Classify the current row: how many columns are low and which one.
  always_comb begin
    w_colLow   = ~r_colSync;
    w_rowCount = 3'd0;
    w_rowCol   = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (w_colLow[c]) begin
        w_rowCount = w_rowCount + 3'd1;
        w_rowCol   = 2'(c);
      end
    end
  end

  // Merge this row into the running frame totals. The low-count saturates at
  // two because anything beyond "one key" is simply MULTI. The frame key is
  // only meaningful when the total is exactly one.
  always_comb begin
    w_sum      = {1'b0, r_lowCount} + ((w_rowCount >= 3'd2) ? 3'd2 : w_rowCount);
    w_totalLow = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_frameKey = (w_rowCount == 3'd1) ? mapKey(r_row, w_rowCol) : r_keyAcc;
    w_slotEnd  = (r_slot == SLOT_LAST);
    w_frameTick = w_slotEnd && (r_row == 2'd3);
    w_isNone   = (w_totalLow == 2'd0);
    w_isSingle = (w_totalLow == 2'd1);
  end

  // Row scanning: each row is held for SCAN_DIV cycles and sampled in its last
  // slot cycle, giving the synchronizer time to settle after the row changes.
  // The frame accumulators clear once row 3 has been folded into the verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot     <= '0;
      r_row      <= 2'd0;
      r_lowCount <= 2'd0;
      r_keyAcc   <= 4'd0;
    end else if (w_slotEnd) begin
      r_slot <= '0;
      r_row  <= r_row + 2'd1;
      if (r_row == 2'd3) begin
        r_lowCount <= 2'd0;
        r_keyAcc   <= 4'd0;
      end else begin
        r_lowCount <= w_totalLow;
        r_keyAcc   <= w_frameKey;
      end
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  // Debounce FSM, stepped once per frame. A press is accepted after
  // DEBOUNCE_SCANS identical single-key frames; it must then see the same
  // number of empty frames before another press can be accepted, so holding
  // a key never auto-repeats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cand     <= 4'd0;
      r_keyCode  <= 4'd0;
      r_keyValid <= 1'b0;
      r_keyDown  <= 1'b0;
    end else begin
      r_keyValid <= 1'b0;
      if (w_frameTick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_isSingle) begin
              r_cand  <= w_frameKey;
              r_cnt   <= CNT_W'(1);
              r_state <= ST_PRESS_DB;
            end
          end
          ST_PRESS_DB: begin
            if (w_isSingle && (w_frameKey == r_cand)) begin
              if (r_cnt == CNT_LAST) begin
                r_cnt      <= '0;
                r_keyCode  <= r_cand;
                r_keyValid <= 1'b1;
                r_keyDown  <= 1'b1;
                r_state    <= ST_HELD;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (w_isNone) begin
              r_cnt   <= CNT_W'(1);
              r_state <= ST_RELEASE_DB;
            end
          end
          default: begin
            if (w_isNone) begin
              if (r_cnt == CNT_LAST) begin
                r_cnt     <= '0;
                r_keyDown <= 1'b0;
                r_state   <= ST_IDLE;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= ST_HELD;
            end
          end
        endcase
      end
    end
  end

  assign kp.row_n     = ~(4'b0001 << r_row);
  assign kp.key_code  = r_keyCode;
  assign kp.key_valid = r_keyValid;
  assign kp.key_down  = r_keyDown;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Models the 4x4 keypad around keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Stimulus pushes the expected key code for every press that should be
// accepted; an independent monitor pops one entry per key_valid pulse.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int FRAME          = 4 * SCAN_DIV;

  logic        clk;
  logic        reset_n;
  logic [15:0] pressed;
  int          checks;
  int          failures;
  int          pulseCount;
  int          expPulses;
  logic [3:0]  expQueue[$];

  keypad_scanner_if kpIf ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kpIf.master)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a column reads low when its pressed key sits on the row
  // currently driven low.
  always_comb begin
    kpIf.col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kpIf.row_n[r] && pressed[r*4+c]) kpIf.col_n[c] = 1'b0;
      end
    end
  end

  // Compare one value and tally the result.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Press or release the key at (row, col).
  task automatic applyStimulus(input int row, input int col, input logic down);
    pressed[row*4+col] = down;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the code of a press that should be accepted.
  task automatic expectKey(input logic [3:0] code);
    expQueue.push_back(code);
    expPulses++;
  endtask

  // Monitor: every key_valid pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (kpIf.key_valid) begin
      pulseCount++;
      if (expQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected key_valid key_code=%0h at %0t", kpIf.key_code, $time);
      end else begin
        logic [3:0] exp;
        exp = expQueue.pop_front();
        checkOutput("key_code at key_valid", int'(kpIf.key_code), int'(exp));
        checkOutput("key_down at key_valid", int'(kpIf.key_down), 1);
      end
    end
  end

  initial begin
    logic [3:0] expRow;
    checks     = 0;
    failures   = 0;
    pulseCount = 0;
    expPulses  = 0;
    pressed    = 16'h0000;
    reset_n    = 1'b0;

    // Test 1: reset values, then the row walk with no keys.
    waitCycles(3);
    checkOutput("reset row_n", int'(kpIf.row_n), 4'hE);
    checkOutput("reset key_valid", int'(kpIf.key_valid), 0);
    checkOutput("reset key_down", int'(kpIf.key_down), 0);
    checkOutput("reset key_code", int'(kpIf.key_code), 0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      expRow = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      checkOutput("row walk", int'(kpIf.row_n), int'(expRow));
      @(negedge clk);
    end
    waitCycles(2 * FRAME);
    checkOutput("idle key_down", int'(kpIf.key_down), 0);
    checkOutput("idle key_code", int'(kpIf.key_code), 0);
    checkOutput("idle pulses", pulseCount, 0);

    // Test 2: hold '5' for six frames -> one pulse, code 5.
    expectKey(4'h5);
    applyStimulus(1, 1, 1'b1);
    waitCycles(6 * FRAME);
    checkOutput("hold 5 key_down", int'(kpIf.key_down), 1);
    checkOutput("hold 5 key_code", int'(kpIf.key_code), 4'h5);
    checkOutput("hold 5 pulses", pulseCount, expPulses);

    // Test 5: release, then press '#'.
    applyStimulus(1, 1, 1'b0);
    waitCycles(5 * FRAME);
    checkOutput("release 5 key_down", int'(kpIf.key_down), 0);
    checkOutput("release 5 key_code held", int'(kpIf.key_code), 4'h5);
    expectKey(4'hF);
    applyStimulus(3, 2, 1'b1);
    waitCycles(6 * FRAME);
    checkOutput("hold # key_code", int'(kpIf.key_code), 4'hF);
    checkOutput("hold # key_down", int'(kpIf.key_down), 1);
    checkOutput("hold # pulses", pulseCount, expPulses);
    applyStimulus(3, 2, 1'b0);
    waitCycles(5 * FRAME);
    checkOutput("release # key_down", int'(kpIf.key_down), 0);

    // Test 3: '9' toggling every frame never debounces.
    for (int f = 0; f < 10; f++) begin
      applyStimulus(2, 2, (f % 2) == 0);
      waitCycles(FRAME);
    end
    applyStimulus(2, 2, 1'b0);
    waitCycles(2 * FRAME);
    checkOutput("toggle 9 pulses", pulseCount, expPulses);
    checkOutput("toggle 9 key_down", int'(kpIf.key_down), 0);

    // Test 4: '1' and '2' together are rejected as a multi-key frame.
    applyStimulus(0, 0, 1'b1);
    applyStimulus(0, 1, 1'b1);
    waitCycles(5 * FRAME);
    checkOutput("multi key_down", int'(kpIf.key_down), 0);
    checkOutput("multi pulses", pulseCount, expPulses);
    checkOutput("multi key_code held", int'(kpIf.key_code), 4'hF);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 1, 1'b0);
    waitCycles(2 * FRAME);

    // Test 6: hold '0' until accepted, reset mid-frame, re-detect.
    expectKey(4'h0);
    applyStimulus(3, 1, 1'b1);
    waitCycles(6 * FRAME);
    checkOutput("hold 0 key_down", int'(kpIf.key_down), 1);
    checkOutput("hold 0 key_code", int'(kpIf.key_code), 4'h0);
    checkOutput("hold 0 pulses", pulseCount, expPulses);
    waitCycles(7);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid reset row_n", int'(kpIf.row_n), 4'hE);
    checkOutput("mid reset key_down", int'(kpIf.key_down), 0);
    checkOutput("mid reset key_valid", int'(kpIf.key_valid), 0);
    checkOutput("mid reset key_code", int'(kpIf.key_code), 0);
    waitCycles(2);
    expectKey(4'h0);
    reset_n = 1'b1;
    waitCycles(6 * FRAME);
    checkOutput("after reset key_down", int'(kpIf.key_down), 1);
    checkOutput("after reset key_code", int'(kpIf.key_code), 4'h0);
    checkOutput("after reset pulses", pulseCount, expPulses);
    checkOutput("queue drained", expQueue.size(), 0);

    applyStimulus(3, 1, 1'b0);
    waitCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
